// File: rtl/uart_tx.sv
// UART transmitter for 7-bit characters: builds a start/data/parity/stop frame
// and shifts it out LSB-first, one bit every CLKS_PER_BIT clocks.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] data_in_uart,
  input  logic       load,
  output logic [9:0] data_out_uart,
  output logic       done_out
);

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned BW         = 4;
  localparam int unsigned CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [9:0]  LINE_IDLE  = 10'h3FF;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_nx;
  logic [9:0]      shreg_nx;
  logic [BW-1:0]   bit_cnt, bit_nx;
  logic [CW-1:0]   cyc_cnt, cyc_nx;
  logic            done_nx;
  logic            parity;

  assign parity = PARITY_ODD ? ~^data_in_uart : ^data_in_uart;

  // Next-state, frame shifting and counter updates
  always_comb begin
    state_nx = state;
    shreg_nx = data_out_uart;
    bit_nx   = bit_cnt;
    cyc_nx   = cyc_cnt;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        shreg_nx = LINE_IDLE;
        bit_nx   = '0;
        cyc_nx   = '0;
        if (load) begin
          shreg_nx = {1'b1, parity, data_in_uart, 1'b0};
          state_nx = SEND;
        end
      end
      SEND: begin
        if (cyc_cnt == CW'(CLKS_PER_BIT - 1)) begin
          cyc_nx   = '0;
          shreg_nx = {1'b1, data_out_uart[9:1]};
          if (bit_cnt == BW'(FRAME_BITS - 1)) begin
            bit_nx   = '0;
            state_nx = IDLE;
            done_nx  = 1'b1;
            shreg_nx = LINE_IDLE;
          end else begin
            bit_nx = bit_cnt + BW'(1);
          end
        end else begin
          cyc_nx = cyc_cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      data_out_uart <= LINE_IDLE;
      bit_cnt       <= '0;
      cyc_cnt       <= '0;
      done_out      <= 1'b0;
    end else begin
      state         <= state_nx;
      data_out_uart <= shreg_nx;
      bit_cnt       <= bit_nx;
      cyc_cnt       <= cyc_nx;
      done_out      <= done_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: even- and odd-parity instances driven in
// lockstep, compared against a frame/time model built from the frame rules.
module tb_uart_tx;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [6:0] data_in_uart;
  logic [9:0] out_even, out_odd;
  logic       done_even, done_odd;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(N), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .rst(rst), .data_in_uart(data_in_uart), .load(load),
    .data_out_uart(out_even), .done_out(done_even));

  uart_tx #(.CLKS_PER_BIT(N), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .data_in_uart(data_in_uart), .load(load),
    .data_out_uart(out_odd), .done_out(done_odd));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Frame = stop(1), parity, 7 data bits LSB first, start(0)
  function automatic logic [9:0] frame_of(input logic [6:0] d, input bit odd);
    int  ones;
    bit  p;
    ones = $countones(d);
    p    = (ones % 2 == 1);
    if (odd) p = !p;
    return {1'b1, p, d, 1'b0};
  endfunction

  // Register contents after k shifts, ones entering from the top
  function automatic logic [9:0] shifted(input logic [9:0] f, input int k);
    logic [19:0] w;
    w = {10'h3FF, f} >> k;
    return w[9:0];
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_even_line"}, 32'(out_even), 32'h3FF);
    check({tag, "_odd_line"},  32'(out_odd),  32'h3FF);
    check({tag, "_done"},      32'({done_even, done_odd}), 32'h0);
  endtask

  // Accept one frame and follow it to its done cycle. busy_at>0 raises load
  // with 7'h55 mid-frame; keep_load holds load high throughout.
  task automatic run_frame(input logic [6:0] d, input int busy_at, input bit keep_load,
                           input logic [6:0] next_d);
    logic [9:0] fe, fo;
    fe = frame_of(d, 1'b0);
    fo = frame_of(d, 1'b1);
    data_in_uart = d;
    load = 1'b1;
    tick();
    if (!keep_load) load = 1'b0;
    check("accept_even", 32'(out_even), 32'(fe));
    check("accept_odd",  32'(out_odd),  32'(fo));
    check("accept_done", 32'({done_even, done_odd}), 32'h0);
    for (int c = 1; c <= 10 * int'(N); c++) begin
      data_in_uart = keep_load && c > 20 ? next_d : 7'($urandom);
      if (busy_at > 0 && c == busy_at) begin
        data_in_uart = 7'h55;
        load = 1'b1;
      end
      if (busy_at > 0 && c == busy_at + 3) load = 1'b0;
      tick();
      if (c < 10 * int'(N)) begin
        check("shift_even", 32'(out_even), 32'(shifted(fe, c / int'(N))));
        check("shift_odd",  32'(out_odd),  32'(shifted(fo, c / int'(N))));
        check("busy_done",  32'({done_even, done_odd}), 32'h0);
      end else begin
        check("end_even_line", 32'(out_even), 32'h3FF);
        check("end_odd_line",  32'(out_odd),  32'h3FF);
        check("end_done", 32'({done_even, done_odd}), 32'h3);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    data_in_uart = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      check_idle("reset_idle");
      tick();
    end

    // Basic frame 7'b0001111 and parity samples
    run_frame(7'h0F, 0, 1'b0, 7'h00);
    tick();
    check_idle("post_basic");
    run_frame(7'h01, 0, 1'b0, 7'h00);
    tick();
    check_idle("post_parity");

    // load while busy is ignored; one done pulse, no second frame
    run_frame(7'h0F, 12, 1'b0, 7'h00);
    for (int i = 0; i < 3 * int'(N); i++) begin
      tick();
      check_idle("post_busy");
    end

    // Reset mid-frame aborts without done
    data_in_uart = 7'h2A;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 1; c < 17; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("abort");
    for (int i = 0; i < 2 * int'(N); i++) begin
      tick();
      check_idle("abort_hold");
    end
    run_frame(7'h2A, 0, 1'b0, 7'h00);
    tick();
    check_idle("post_abort");

    // Back-to-back with load held high, data changed mid-frame
    run_frame(7'h0F, 0, 1'b1, 7'h70);
    run_frame(7'h70, 0, 1'b0, 7'h00);
    tick();
    check_idle("post_b2b");

    // Randomized frames, some back-to-back
    for (int r = 0; r < 8; r++) begin
      logic [6:0] d;
      logic [6:0] nd;
      bit b2b;
      d   = 7'($urandom);
      nd  = 7'($urandom);
      b2b = 1'($urandom);
      run_frame(d, 0, b2b, nd);
      if (b2b) begin
        run_frame(nd, 0, 1'b0, 7'h00);
      end
      tick();
      check_idle("rand_gap");
      for (int i = 0; i < int'($urandom_range(0, 5)); i++) tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
